// File: rtl/coarse_timing_sync_pkg.sv
// ============================================================================
// Module : coarse_timing_sync_pkg
// Brief  : Shared widths and FSM state encoding for the coarse timing detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coarse_timing_sync_pkg;

    localparam int FIXED_POINT_WIDTH = 16;
    localparam int FIFO_DEPTH        = 256;

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        WARM    = 3'd1,
        SEARCH  = 3'd2,
        PLATEAU = 3'd3,
        LOCKED  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/coarse_timing_sync_moving_sum.sv
// ============================================================================
// Module : moving_sum
// Brief  : WIN-deep tap line with running accumulator (add newest, drop oldest).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module moving_sum #(
    parameter int WIN       = 16,
    parameter int IW        = 32,
    parameter int IS_SIGNED = 1,
    parameter int SW        = IW + $clog2(WIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [IW-1:0] din,
    output logic [SW-1:0] sum
);

    logic [IW-1:0] r_taps [WIN];
    logic [SW-1:0] w_new_ext;
    logic [SW-1:0] w_old_ext;

    generate
        if (IS_SIGNED != 0) begin : g_signed
            assign w_new_ext = {{(SW-IW){din[IW-1]}}, din};
            assign w_old_ext = {{(SW-IW){r_taps[WIN-1][IW-1]}}, r_taps[WIN-1]};
        end else begin : g_unsigned
            assign w_new_ext = {{(SW-IW){1'b0}}, din};
            assign w_old_ext = {{(SW-IW){1'b0}}, r_taps[WIN-1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) r_taps[i] <= '0;
            sum <= '0;
        end else if (en) begin
            r_taps[0] <= din;
            for (int i = 1; i < WIN; i++) r_taps[i] <= r_taps[i-1];
            // Wrapping arithmetic is exact: the true sum always fits in SW bits.
            sum <= sum + w_new_ext - w_old_ext;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coarse_timing_sync.sv
// ============================================================================
// Module : coarse_timing_sync
// Brief  : Delayed-autocorrelation plateau detector for coarse frame timing.
// Config : define COARSE_P_LOCK_EN to add the p_lock output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coarse_timing_sync
    import coarse_timing_sync_pkg::*;
#(
    parameter int DELAY       = 16,
    parameter int WIN         = 16,
    parameter int THR         = 6,
    parameter int PLATEAU_LEN = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    input  logic signed [FIXED_POINT_WIDTH-1:0] s_data,
    input  logic                                clear,
    output logic                                fifo_w_en,
    output logic        [FIXED_POINT_WIDTH-1:0] fifo_din,
    output logic                                fifo_r_en,
    input  logic        [FIXED_POINT_WIDTH-1:0] fifo_dout,
    input  logic                                fifo_r_valid,
    input  logic        [8:0]                   fifo_count,
    output logic                                detect,
    output logic                                locked,
    output logic        [15:0]                  start_idx
`ifdef COARSE_P_LOCK_EN
    ,
    output logic signed [2*FIXED_POINT_WIDTH+$clog2(WIN)-1:0] p_lock
`endif
);

    localparam int W  = FIXED_POINT_WIDTH;
    localparam int LW = $clog2(WIN);
    localparam int SW = 2*W + LW;
    localparam int CW = SW + 8;
    localparam logic [8:0]    C_DELAY   = 9'(DELAY);
    localparam logic [LW-1:0] C_WIN_M1  = LW'(WIN - 1);
    localparam logic [7:0]    C_PLEN_M1 = 8'(PLATEAU_LEN - 1);
    localparam logic [CW-1:0] C_THR     = CW'(THR);

    state_t                r_state, w_state_nxt;
    logic signed [W-1:0]   r_x_d;
    logic signed [2*W-1:0] r_c;
    logic [2*W-1:0]        r_e;
    logic                  r_prod_v, r_m_v;
    logic [15:0]           r_sample_cnt, r_idx_prod, r_idx_m;
    logic [SW-1:0]         w_p_raw, w_r;
    logic signed [SW-1:0]  w_p;
    logic [CW-1:0]         w_lhs, w_rhs;
    logic                  w_qualify, w_clear_ok;
    logic [7:0]            r_run, w_run_nxt;
    logic [LW-1:0]         r_warm, w_warm_nxt;
    logic [15:0]           r_cand, w_cand_nxt, r_start, w_start_nxt;
    logic                  r_detect, w_detect_nxt;
    logic signed [2*W-1:0] w_x_ext, w_y_ext;

    assign fifo_w_en = s_valid;
    assign fifo_din  = s_data;
    assign fifo_r_en = s_valid && (fifo_count == C_DELAY);

    assign w_x_ext = {{W{r_x_d[W-1]}}, r_x_d};
    assign w_y_ext = {{W{fifo_dout[W-1]}}, fifo_dout};
    assign w_clear_ok = clear && (r_state != FILL) && (r_state != WARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_d        <= '0;
            r_c          <= '0;
            r_e          <= '0;
            r_prod_v     <= 1'b0;
            r_m_v        <= 1'b0;
            r_sample_cnt <= '0;
            r_idx_prod   <= '0;
            r_idx_m      <= '0;
        end else begin
            r_prod_v <= fifo_r_valid;
            r_m_v    <= r_prod_v;
            if (fifo_r_en) r_x_d <= s_data;
            if (fifo_r_valid) begin
                r_c        <= w_x_ext * w_y_ext;
                r_e        <= w_x_ext * w_x_ext;
                r_idx_prod <= r_sample_cnt;
            end
            if (r_prod_v) r_idx_m <= r_idx_prod;
            if (w_clear_ok)        r_sample_cnt <= '0;
            else if (fifo_r_valid) r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    moving_sum #(.WIN(WIN), .IW(2*W), .IS_SIGNED(1), .SW(SW)) u_p_sum (
        .clk (clk),
        .rst (rst),
        .en  (r_prod_v),
        .din (r_c),
        .sum (w_p_raw)
    );

    moving_sum #(.WIN(WIN), .IW(2*W), .IS_SIGNED(0), .SW(SW)) u_r_sum (
        .clk (clk),
        .rst (rst),
        .en  (r_prod_v),
        .din (r_e),
        .sum (w_r)
    );

    assign w_p = w_p_raw;
    // P is only compared when positive, so its raw bits serve as the magnitude.
    assign w_lhs = {{(CW-SW-3){1'b0}}, w_p_raw, 3'b000};
    assign w_rhs = {{(CW-SW){1'b0}}, w_r} * C_THR;
    assign w_qualify = !w_p[SW-1] && (w_p != '0) && (w_lhs >= w_rhs);

    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_warm_nxt   = r_warm;
        w_cand_nxt   = r_cand;
        w_start_nxt  = r_start;
        w_detect_nxt = 1'b0;
        case (r_state)
            FILL: begin
                if (fifo_count == C_DELAY) begin
                    w_state_nxt = WARM;
                    w_warm_nxt  = '0;
                end
            end
            WARM: begin
                if (r_m_v) begin
                    if (r_warm == C_WIN_M1) w_state_nxt = SEARCH;
                    else                    w_warm_nxt  = r_warm + 1'b1;
                end
            end
            SEARCH: begin
                if (r_m_v && w_qualify) begin
                    w_cand_nxt = r_idx_m;
                    w_run_nxt  = 8'd1;
                    if (C_PLEN_M1 == 8'd0) begin
                        w_state_nxt  = LOCKED;
                        w_detect_nxt = 1'b1;
                        w_start_nxt  = r_idx_m;
                    end else begin
                        w_state_nxt = PLATEAU;
                    end
                end
            end
            PLATEAU: begin
                if (r_m_v) begin
                    if (!w_qualify) begin
                        w_state_nxt = SEARCH;
                        w_run_nxt   = 8'd0;
                    end else if (r_run == C_PLEN_M1) begin
                        w_state_nxt  = LOCKED;
                        w_detect_nxt = 1'b1;
                        w_start_nxt  = r_cand;
                        w_run_nxt    = r_run + 8'd1;
                    end else begin
                        w_run_nxt = r_run + 8'd1;
                    end
                end
            end
            LOCKED: begin
                w_state_nxt = LOCKED;
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
        // Re-arm wins over a lock landing in the same cycle.
        if (w_clear_ok) begin
            w_state_nxt  = SEARCH;
            w_run_nxt    = 8'd0;
            w_detect_nxt = 1'b0;
            w_start_nxt  = r_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FILL;
            r_run    <= '0;
            r_warm   <= '0;
            r_cand   <= '0;
            r_start  <= '0;
            r_detect <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_warm   <= w_warm_nxt;
            r_cand   <= w_cand_nxt;
            r_start  <= w_start_nxt;
            r_detect <= w_detect_nxt;
        end
    end

    assign detect    = r_detect;
    assign locked    = (r_state == LOCKED);
    assign start_idx = r_start;

`ifdef COARSE_P_LOCK_EN
    logic signed [SW-1:0] r_p_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_p_lock <= '0;
        else if (w_clear_ok)   r_p_lock <= '0;
        else if (w_detect_nxt) r_p_lock <= w_p;
    end

    assign p_lock = r_p_lock;
`endif

endmodule

`default_nettype wire
